// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types and LFSR constants for the F1 start controller
package f1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LIGHTS,
    ST_HOLD,
    ST_RUN,
    ST_DONE,
    ST_FAULT
  } f1_state_t;

  // x^7 + x^6 + 1, shifted left with the feedback entering bit 0
  localparam int         LFSR_W      = 7;
  localparam int         LFSR_TAP_HI = 6;
  localparam int         LFSR_TAP_LO = 5;
  localparam logic [6:0] LFSR_SEED   = 7'h01;

endpackage

// File: rtl/clktick.sv
// rtl/clktick.sv - enable-gated divider, one-cycle tick when the count reaches N-1
module clktick #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] N,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == (N - CNT_W'(1)));
  assign tick   = en & at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/f1_start_controller.sv
// rtl/f1_start_controller.sv - F1 start-light sequencer with random hold and reaction timer
module f1_start_controller
  import f1_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TICK_DIV   = 24,
  parameter int TIME_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic                  btn,
  output logic [WIDTH-1:0]      data_out,
  output logic [TIME_WIDTH-1:0] react_time,
  output logic                  time_valid,
  output logic                  jump_start,
  output logic                  busy
);

  localparam int CNT_W = $clog2(TICK_DIV + 1);

  f1_state_t             state_q, state_d;
  logic                  trigger_q;
  logic [LFSR_W-1:0]     lfsr_q;
  logic [LFSR_W-1:0]     hold_q, hold_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [TIME_WIDTH-1:0] react_cnt_q, react_cnt_d;
  logic [TIME_WIDTH-1:0] react_time_q, react_time_d;
  logic                  time_valid_q, time_valid_d;
  logic                  jump_q, jump_d;
  logic                  busy_q, busy_d;

  logic start;
  logic tick;
  logic tick_en;
  logic tick_rst;
  logic all_on;
  logic idle_like;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAULT);
  assign start     = trigger & ~trigger_q & idle_like;
  assign tick_en   = (state_q == ST_LIGHTS) || (state_q == ST_HOLD);
  // Restarting clears the divider so the first light step is a full period long
  assign tick_rst  = rst | start;
  assign all_on    = &data_q;

  clktick #(
    .CNT_W(CNT_W)
  ) u_tick (
    .clk (clk),
    .rst (tick_rst),
    .en  (tick_en),
    .N   (CNT_W'(TICK_DIV)),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      trigger_q    <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      hold_q       <= '0;
      data_q       <= '0;
      react_cnt_q  <= '0;
      react_time_q <= '0;
      time_valid_q <= 1'b0;
      jump_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      trigger_q    <= trigger;
      lfsr_q       <= {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
      hold_q       <= hold_d;
      data_q       <= data_d;
      react_cnt_q  <= react_cnt_d;
      react_time_q <= react_time_d;
      time_valid_q <= time_valid_d;
      jump_q       <= jump_d;
      busy_q       <= busy_d;
    end
  end

  // A press in LIGHTS/HOLD outranks any tick in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start) state_d = ST_LIGHTS;
      end
      ST_LIGHTS: begin
        if (btn)                  state_d = ST_FAULT;
        else if (tick && all_on)  state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (btn)                              state_d = ST_FAULT;
        else if (tick && hold_q == 7'd1)      state_d = ST_RUN;
      end
      ST_RUN: begin
        if (btn) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d       = data_q;
    hold_d       = hold_q;
    react_cnt_d  = react_cnt_q;
    react_time_d = react_time_q;
    time_valid_d = time_valid_q;
    jump_d       = jump_q;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start) begin
          data_d       = WIDTH'(1);
          time_valid_d = 1'b0;
          jump_d       = 1'b0;
          busy_d       = 1'b1;
        end
      end
      ST_LIGHTS, ST_HOLD: begin
        if (btn) begin
          jump_d = 1'b1;
          data_d = '0;
          busy_d = 1'b0;
        end else if (tick) begin
          if (state_q == ST_LIGHTS) begin
            if (all_on) hold_d = lfsr_q;
            else        data_d = {data_q[WIDTH-2:0], 1'b1};
          end else if (hold_q == 7'd1) begin
            data_d      = '0;
            react_cnt_d = '0;
          end else begin
            hold_d = hold_q - 7'd1;
          end
        end
      end
      ST_RUN: begin
        if (btn) begin
          react_time_d = react_cnt_q;
          time_valid_d = 1'b1;
          busy_d       = 1'b0;
        end else if (react_cnt_q != '1) begin
          react_cnt_d = react_cnt_q + TIME_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  assign data_out   = data_q;
  assign react_time = react_time_q;
  assign time_valid = time_valid_q;
  assign jump_start = jump_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_f1_start_controller.sv
// tb/tb_f1_start_controller.sv - directed self-checking bench for f1_start_controller
module tb_f1_start_controller;

  logic        clk;
  logic        rst;
  logic        trig_a, btn_a, trig_b, btn_b;
  logic [7:0]  data_a;
  logic [15:0] rt_a;
  logic        tv_a, js_a, busy_a;
  logic [3:0]  data_b;
  logic [3:0]  rt_b;
  logic        tv_b, js_b, busy_b;

  int total;
  int bad;

  logic [6:0] sh_lfsr;

  f1_start_controller #(.WIDTH(8), .TICK_DIV(4), .TIME_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .trigger(trig_a), .btn(btn_a),
    .data_out(data_a), .react_time(rt_a), .time_valid(tv_a),
    .jump_start(js_a), .busy(busy_a)
  );

  f1_start_controller #(.WIDTH(4), .TICK_DIV(4), .TIME_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .trigger(trig_b), .btn(btn_b),
    .data_out(data_b), .react_time(rt_b), .time_valid(tv_b),
    .jump_start(js_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Reference x^7+x^6+1 generator running alongside both designs
  always @(posedge clk) begin
    if (rst) sh_lfsr <= 7'h01;
    else     sh_lfsr <= {sh_lfsr[5:0], sh_lfsr[6] ^ sh_lfsr[5]};
  end

  function automatic logic [6:0] lfsr_fwd(input logic [6:0] v, input int n);
    logic [6:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[5:0], r[6] ^ r[5]};
    return r;
  endfunction

  // Fires a trigger edge timed so the hold count loaded 'lat' edges later equals 'target'.
  // Returns at the falling edge right after the start was sampled.
  task automatic launch(input bit sel, input int lat, input logic [6:0] target);
    int n;
    n = 0;
    while (lfsr_fwd(sh_lfsr, lat) != target && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL launch_align: waited %0d cycles, hold value %h never reached", n, target);
    end
    if (sel) trig_b = 1'b1;
    else     trig_a = 1'b1;
    @(negedge clk);
    trig_a = 1'b0;
    trig_b = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({data_a, rt_a, tv_a, js_a, busy_a} !== 27'd0) begin
      bad++;
      $display("FAIL reset_a: got data=%h rt=%h tv=%b js=%b busy=%b want all 0", data_a, rt_a, tv_a, js_a, busy_a);
    end
    total++;
    if ({data_b, rt_b, tv_b, js_b, busy_b} !== 11'd0) begin
      bad++;
      $display("FAIL reset_b: got data=%h rt=%h tv=%b js=%b busy=%b want all 0", data_b, rt_b, tv_b, js_b, busy_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturate;
    launch(1'b1, 16, 7'h01);
    repeat (20) @(negedge clk);
    total++;
    if (data_b !== 4'h0 || busy_b !== 1'b1) begin
      bad++;
      $display("FAIL sat_run_entry: got data=%h busy=%b want data=0 busy=1", data_b, busy_b);
    end
    repeat (20) @(negedge clk);
    btn_b = 1'b1;
    @(negedge clk);
    btn_b = 1'b0;
    total++;
    if (rt_b !== 4'hF || tv_b !== 1'b1 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL sat_react: got rt=%h tv=%b busy=%b want rt=f tv=1 busy=0", rt_b, tv_b, busy_b);
    end
  endtask

  task automatic test_lights_hold;
    logic [7:0] exp_d;
    launch(1'b0, 32, 7'h05);
    for (int i = 0; i < 52; i++) begin
      exp_d = (i < 28) ? 8'((1 << (i / 4 + 1)) - 1) : 8'hFF;
      total++;
      if (data_a !== exp_d || busy_a !== 1'b1) begin
        bad++;
        $display("FAIL lights_c%0d: got data=%h busy=%b want data=%h busy=1", i, data_a, busy_a, exp_d);
      end
      if (i == 10) trig_a = 1'b1;
      if (i == 11) trig_a = 1'b0;
      @(negedge clk);
    end
    total++;
    if (data_a !== 8'h00 || busy_a !== 1'b1 || tv_a !== 1'b0 || js_a !== 1'b0) begin
      bad++;
      $display("FAIL lights_out: got data=%h busy=%b tv=%b js=%b want 00 1 0 0", data_a, busy_a, tv_a, js_a);
    end
  endtask

  task automatic test_react;
    repeat (36) @(negedge clk);
    total++;
    if (data_a !== 8'h00 || tv_a !== 1'b0) begin
      bad++;
      $display("FAIL react_wait: got data=%h tv=%b want 00 0", data_a, tv_a);
    end
    btn_a = 1'b1;
    @(negedge clk);
    btn_a = 1'b0;
    total++;
    if (rt_a !== 16'd36 || tv_a !== 1'b1 || busy_a !== 1'b0 || data_a !== 8'h00) begin
      bad++;
      $display("FAIL react_done: got rt=%0d tv=%b busy=%b data=%h want 36 1 0 00", rt_a, tv_a, busy_a, data_a);
    end
    btn_a = 1'b1;
    repeat (3) @(negedge clk);
    btn_a = 1'b0;
    total++;
    if (rt_a !== 16'd36 || tv_a !== 1'b1 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL done_hold: got rt=%0d tv=%b busy=%b want 36 1 0", rt_a, tv_a, busy_a);
    end
  endtask

  task automatic test_restart_jump;
    launch(1'b0, 32, 7'h03);
    total++;
    if (data_a !== 8'h01 || tv_a !== 1'b0 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL restart_done: got data=%h tv=%b busy=%b want 01 0 1", data_a, tv_a, busy_a);
    end
    repeat (43) @(negedge clk);
    total++;
    if (data_a !== 8'hFF || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL hold_last: got data=%h busy=%b want ff 1", data_a, busy_a);
    end
    btn_a = 1'b1;
    @(negedge clk);
    btn_a = 1'b0;
    total++;
    if (js_a !== 1'b1 || data_a !== 8'h00 || tv_a !== 1'b0 || busy_a !== 1'b0 || rt_a !== 16'd36) begin
      bad++;
      $display("FAIL jump: got js=%b data=%h tv=%b busy=%b rt=%0d want 1 00 0 0 36", js_a, data_a, tv_a, busy_a, rt_a);
    end
    btn_a = 1'b1;
    repeat (3) @(negedge clk);
    btn_a = 1'b0;
    total++;
    if (js_a !== 1'b1 || data_a !== 8'h00 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL fault_hold: got js=%b data=%h busy=%b want 1 00 0", js_a, data_a, busy_a);
    end
    launch(1'b0, 32, 7'h02);
    total++;
    if (js_a !== 1'b0 || data_a !== 8'h01 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL restart_fault: got js=%b data=%h busy=%b want 0 01 1", js_a, data_a, busy_a);
    end
  endtask

  task automatic test_reset_mid;
    repeat (5) @(negedge clk);
    total++;
    if (data_a !== 8'h03) begin
      bad++;
      $display("FAIL mid_lights: got data=%h want 03", data_a);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({data_a, rt_a, tv_a, js_a, busy_a} !== 27'd0) begin
      bad++;
      $display("FAIL rst_mid_a: got data=%h rt=%h tv=%b js=%b busy=%b want all 0", data_a, rt_a, tv_a, js_a, busy_a);
    end
    total++;
    if ({data_b, rt_b, tv_b, js_b, busy_b} !== 11'd0) begin
      bad++;
      $display("FAIL rst_mid_b: got data=%h rt=%h tv=%b busy=%b want all 0", data_b, rt_b, tv_b, busy_b);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (data_a !== 8'h00 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL post_rst_idle: got data=%h busy=%b want 00 0", data_a, busy_a);
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    trig_a = 1'b0;
    btn_a  = 1'b0;
    trig_b = 1'b0;
    btn_b  = 1'b0;
    total  = 0;
    bad    = 0;
    test_reset;
    test_saturate;
    test_lights_hold;
    test_react;
    test_restart_jump;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
